// File: rtl/fs_pkg.sv
// Shared types and elaboration helpers for the serial full subtractor.
package fs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fs_state_t;

  // Number of RUN cycles needed to consume the whole operand.
  function automatic int fs_nstep(input int width, input int digit);
    return width / digit;
  endfunction

  // Step counter width; a single-step configuration still needs one bit.
  function automatic int fs_cnt_w(input int nstep);
    return (nstep <= 1) ? 1 : $clog2(nstep);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - br_in, with borrow out.
module fs_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_br,
  output logic o_d,
  output logic o_br
);

  assign o_d  = i_x ^ i_y ^ i_br;
  assign o_br = (~i_x & i_y) | (i_y & i_br) | (~i_x & i_br);

endmodule

// File: rtl/fs_serial.sv
// Multi-cycle full subtractor: diff = a - b - bin, DIGIT bits per clock,
// borrow carried in a register between digits.
module fs_serial
  import fs_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int NSTEP = fs_nstep(WIDTH, DIGIT);
  localparam int CNT_W = fs_cnt_w(NSTEP);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEP - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("fs_serial: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  fs_state_t        r_state;
  fs_state_t        w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff_sh;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;

  logic [DIGIT-1:0]       w_d;
  logic [DIGIT:0]         w_br_chain;
  logic [WIDTH+DIGIT-1:0] w_diff_cat;
  logic [WIDTH-1:0]       w_diff_next;
  logic                   w_last;

  // Borrow ripples through DIGIT cells, seeded by the registered borrow.
  assign w_br_chain[0] = r_br;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      fs_cell u_cell (
        .i_x  (r_a_sh[i]),
        .i_y  (r_b_sh[i]),
        .i_br (w_br_chain[i]),
        .o_d  (w_d[i]),
        .o_br (w_br_chain[i+1])
      );
    end
  endgenerate

  // New digit enters at the MSB end; after NSTEP steps digit 0 sits at bit 0.
  // Built by concatenation so DIGIT == WIDTH needs no empty slice.
  assign w_diff_cat  = {w_d, r_diff_sh};
  assign w_diff_next = w_diff_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_last      = (r_cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start is honoured only in IDLE, DONE lasts one cycle.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch forms.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, per-step shifting, and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift registers are reset as well, not just control state,
      // so nothing internal is ever X and an aborted run leaves no residue.
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_diff_sh <= '0;
      r_br      <= 1'b0;
      r_cnt     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_br      <= bin;
            r_cnt     <= '0;
            r_diff_sh <= '0;
          end
        end
        RUN: begin
          r_a_sh    <= r_a_sh >> DIGIT;
          r_b_sh    <= r_b_sh >> DIGIT;
          r_diff_sh <= w_diff_next;
          r_br      <= w_br_chain[DIGIT];
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff <= w_diff_next;
            r_bout <= w_br_chain[DIGIT];
            r_zero <= (w_diff_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;

endmodule

// File: tb/tb_fs_serial.sv
// Self-checking bench for fs_serial: 16/4, 8/1 and 8/8 configurations
// compared against an arithmetic reference of a - b - bin.
module tb_fs_serial;

  logic clk;
  logic rst16_n;
  logic rst8_n;

  logic        start16;
  logic [15:0] a16, b16;
  logic        bin16;
  logic        busy16, done16, bout16, zero16;
  logic [15:0] diff16;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        bin8;
  logic        busy81, done81, bout81, zero81;
  logic [7:0]  diff81;
  logic        busy88, done88, bout88, zero88;
  logic [7:0]  diff88;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  logic [15:0] exp_prev16;
  logic        exp_prev_bout16;
  logic        exp_prev_zero16;

  logic [15:0] ha   [0:24];
  logic [15:0] hb   [0:24];
  logic        hbin [0:24];

  fs_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst16_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .zero(zero16)
  );

  fs_serial #(.WIDTH(8), .DIGIT(1)) u_dut81 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy81), .done(done81), .diff(diff81), .bout(bout81), .zero(zero81)
  );

  fs_serial #(.WIDTH(8), .DIGIT(8)) u_dut88 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy88), .done(done88), .diff(diff88), .bout(bout88), .zero(zero88)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {bout, diff} for a w-bit subtract, straight from the arithmetic.
  function automatic logic [16:0] ref_sub(input longint a, input longint b,
                                          input int bin, input int w);
    longint      t;
    longint      mask;
    logic [16:0] r;
    t      = a - b - longint'(bin);
    mask   = (longint'(1) << w) - 1;
    r      = '0;
    r[15:0] = 16'(t & mask);
    r[16]   = (a < (b + longint'(bin)));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One 16-bit operation started in the current cycle (cycle 0); extra_start
  // bit c drives start during cycle c to probe that busy-time starts are ignored.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input logic [6:0] extra_start);
    logic [16:0] r;
    r       = ref_sub(longint'(a), longint'(b), int'(bin), 16);
    a16     = a;
    b16     = b;
    bin16   = bin;
    start16 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      start16 = extra_start[c];
      a16     = 16'($urandom);
      b16     = 16'($urandom);
      bin16   = 1'($urandom);
      check($sformatf("busy16 c%0d", c), 32'(busy16), 32'(c <= 5));
      check($sformatf("done16 c%0d", c), 32'(done16), 32'(c == 5));
      if (c < 5) begin
        check("diff16 held", 32'(diff16), 32'(exp_prev16));
        check("bout16 held", 32'(bout16), 32'(exp_prev_bout16));
        check("zero16 held", 32'(zero16), 32'(exp_prev_zero16));
      end
      if (c == 5) begin
        check("diff16", 32'(diff16), 32'(r[15:0]));
        check("bout16", 32'(bout16), 32'(r[16]));
        check("zero16", 32'(zero16), 32'(r[15:0] == 16'h0));
        exp_prev16      = r[15:0];
        exp_prev_bout16 = r[16];
        exp_prev_zero16 = (r[15:0] == 16'h0);
      end
    end
  endtask

  // One operation on both 8-bit instances in parallel; ends in cycle 10 where
  // both are idle again, so the next call may start immediately.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [16:0] r;
    int          fd1;
    int          fd8;
    logic [7:0]  d1, d8;
    logic        bo1, bo8, z1, z8;
    r   = ref_sub(longint'(a), longint'(b), int'(bin), 8);
    fd1 = -1;
    fd8 = -1;
    d1  = 'x; d8 = 'x; bo1 = 1'bx; bo8 = 1'bx; z1 = 1'bx; z8 = 1'bx;
    a8     = a;
    b8     = b;
    bin8   = bin;
    start8 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      bin8   = 1'($urandom);
      if (done81 === 1'b1 && fd1 < 0) begin
        fd1 = c; d1 = diff81; bo1 = bout81; z1 = zero81;
      end
      if (done88 === 1'b1 && fd8 < 0) begin
        fd8 = c; d8 = diff88; bo8 = bout88; z8 = zero88;
      end
    end
    check("lat81",  32'(fd1), 32'd9);
    check("diff81", 32'(d1),  32'(r[7:0]));
    check("bout81", 32'(bo1), 32'(r[16]));
    check("zero81", 32'(z1),  32'(r[7:0] == 8'h0));
    check("lat88",  32'(fd8), 32'd2);
    check("diff88", 32'(d8),  32'(r[7:0]));
    check("bout88", 32'(bo8), 32'(r[16]));
    check("zero88", 32'(z8),  32'(r[7:0] == 8'h0));
  endtask

  initial begin
    logic [16:0] r;
    logic [7:0]  bsel [0:7];

    rst16_n = 1'b0;
    rst8_n  = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    start8  = 1'b0; a8  = '0; b8  = '0; bin8  = 1'b0;
    exp_prev16      = '0;
    exp_prev_bout16 = 1'b0;
    exp_prev_zero16 = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst busy16", 32'(busy16), 32'd0);
    check("rst done16", 32'(done16), 32'd0);
    check("rst diff16", 32'(diff16), 32'd0);
    check("rst bout16", 32'(bout16), 32'd0);
    check("rst zero16", 32'(zero16), 32'd0);
    check("rst busy81", 32'(busy81), 32'd0);
    check("rst diff81", 32'(diff81), 32'd0);
    check("rst busy88", 32'(busy88), 32'd0);
    check("rst diff88", 32'(diff88), 32'd0);
    rst16_n = 1'b1;
    rst8_n  = 1'b1;

    // Directed 16/4 operations.
    op16(16'h1234, 16'h0234, 1'b0, 7'b0);
    op16(16'h0000, 16'h0001, 1'b0, 7'b0);
    op16(16'h8000, 16'h7FFF, 1'b1, 7'b0);
    op16(16'hFFFF, 16'hFFFF, 1'b1, 7'b0);
    op16(16'hFFFF, 16'h0000, 1'b0, 7'b0);

    // Starts in cycles 2 and 5 are ignored; the next call starts in cycle 6.
    op16(16'h00FF, 16'h000F, 1'b0, 7'b0100100);
    op16(16'hABCD, 16'h1234, 1'b1, 7'b0);

    // Randomized 16/4 operations.
    for (int k = 0; k < 20; k++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 7'b0);
    end

    // Reset in cycle 3 of a running operation.
    a16 = 16'h5555; b16 = 16'h1111; bin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1; start16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst16_n = 1'b0;
    #1;
    check("abort busy16", 32'(busy16), 32'd0);
    check("abort done16", 32'(done16), 32'd0);
    check("abort diff16", 32'(diff16), 32'd0);
    check("abort bout16", 32'(bout16), 32'd0);
    check("abort zero16", 32'(zero16), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort no done", 32'(done16), 32'd0);
    end
    rst16_n         = 1'b1;
    exp_prev16      = '0;
    exp_prev_bout16 = 1'b0;
    exp_prev_zero16 = 1'b0;
    op16(16'h5555, 16'h1111, 1'b0, 7'b0);
    op16(16'h0001, 16'h0002, 1'b1, 7'b0);

    // start held high for cycles 0..19: operands sampled in cycles 0, 6, 12, 18.
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        check($sformatf("held busy c%0d", c), 32'(busy16), 32'((c % 6) != 0));
        check($sformatf("held done c%0d", c), 32'(done16), 32'((c % 6) == 5));
        if ((c % 6) == 5) begin
          r = ref_sub(longint'(ha[(c/6)*6]), longint'(hb[(c/6)*6]), int'(hbin[(c/6)*6]), 16);
          check("held diff", 32'(diff16), 32'(r[15:0]));
          check("held bout", 32'(bout16), 32'(r[16]));
          check("held zero", 32'(zero16), 32'(r[15:0] == 16'h0));
        end
      end
      ha[c]   = 16'($urandom);
      hb[c]   = 16'($urandom);
      hbin[c] = 1'($urandom);
      a16     = ha[c];
      b16     = hb[c];
      bin16   = hbin[c];
      start16 = (c < 20);
    end

    // 8-bit configurations: every a against corner and random subtrahends.
    for (int ia = 0; ia < 256; ia++) begin
      bsel[0] = 8'h00; bsel[1] = 8'h01; bsel[2] = 8'h7F; bsel[3] = 8'h80;
      bsel[4] = 8'hFE; bsel[5] = 8'hFF; bsel[6] = 8'(ia); bsel[7] = 8'($urandom);
      for (int ib = 0; ib < 8; ib++) begin
        for (int ibin = 0; ibin < 2; ibin++) begin
          op8(8'(ia), bsel[ib], 1'(ibin));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
